// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector.
//   ST_IDLE / ST_LOAD / ST_DETECT : one-hot controller state codes
//   idx_width()                   : counter width able to hold 0..n inclusive
package seq_det_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'b001;
   localparam state_t ST_LOAD   = 3'b010;
   localparam state_t ST_DETECT = 3'b100;

   // Counters must reach the value n itself (e.g. fill == PAT_W), hence n+1.
   function automatic int idx_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked equality compare of the candidate history window against the pattern.
//   i_hist    : candidate window, bit 0 = oldest received bit
//   i_pattern : stored pattern, bit 0 = first loaded bit
//   i_mask    : 1 = don't care for that bit position
//   o_eq      : 1 when every unmasked bit agrees
module seq_match_cmp #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_hist,
   input  logic [W-1:0] i_pattern,
   input  logic [W-1:0] i_mask,
   output logic         o_eq
);

   assign o_eq = (((i_hist ^ i_pattern) & ~i_mask) == '0);

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector.
//   clk, rst            : clock, synchronous active-high reset
//   load                : request/hold serial pattern load; drop mid-load to abort
//   din_valid, din      : qualified serial bit stream (pattern source and search stream)
//   ovl_mode            : 1 = overlapping matches, 0 = non-overlapping
//   mask_in             : don't-care mask, captured when a load completes
//   dout                : registered one-cycle match pulse
//   match_cnt           : saturating match count, cleared on load completion
//   busy                : high while loading
//   pat_valid           : high while a complete pattern is held
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             din_valid,
   input  logic             din,
   input  logic             ovl_mode,
   input  logic [PAT_W-1:0] mask_in,
   output logic             dout,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             pat_valid
);

   localparam int               IW      = idx_width(PAT_W);
   localparam logic [IW-1:0]    FULL    = IW'(PAT_W);
   localparam logic [IW-1:0]    LAST    = IW'(PAT_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_state_n;
   logic [PAT_W-1:0] r_pattern;
   logic [PAT_W-1:0] r_mask;
   // Only the newest PAT_W-1 bits are kept: the oldest bit of the window
   // is always shifted out before it could take part in a compare.
   logic [PAT_W-2:0] r_tail;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    r_fill;
   logic             r_dout;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pat_valid;

   logic [PAT_W-1:0] w_hist_n;
   logic [IW-1:0]    w_fill_n;
   logic             w_eq;
   logic             w_match;
   logic             w_load_last;
   logic             w_busy;

   assign w_hist_n    = {din, r_tail};
   assign w_fill_n    = (r_fill == FULL) ? FULL : r_fill + IW'(1);
   assign w_match     = (w_fill_n == FULL) && w_eq;
   assign w_load_last = (r_idx == LAST);

   seq_match_cmp #(.W(PAT_W)) u_cmp (
      .i_hist    (w_hist_n),
      .i_pattern (r_pattern),
      .i_mask    (r_mask),
      .o_eq      (w_eq)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_n;
   end

   // Next-state logic; abort (load dropped) wins over a same-cycle last bit
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         ST_IDLE: begin
            if (load)             w_state_n = ST_LOAD;
            else if (r_pat_valid) w_state_n = ST_DETECT;
         end
         ST_LOAD: begin
            if (!load)                         w_state_n = ST_IDLE;
            else if (din_valid && w_load_last) w_state_n = ST_IDLE;
         end
         ST_DETECT: begin
            if (load) w_state_n = ST_LOAD;
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      w_busy = (r_state == ST_LOAD);
   end

   // Datapath: pattern shifter, history, fill counter, output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern   <= '0;
         r_mask      <= '0;
         r_tail      <= '0;
         r_idx       <= '0;
         r_fill      <= '0;
         r_dout      <= 1'b0;
         r_cnt       <= '0;
         r_pat_valid <= 1'b0;
      end else begin
         r_dout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_idx       <= '0;
                  r_pat_valid <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (load && din_valid) begin
                  for (int k = 0; k < PAT_W; k++)
                     if (r_idx == IW'(k)) r_pattern[k] <= din;
                  r_idx <= r_idx + IW'(1);
                  if (w_load_last) begin
                     r_mask      <= mask_in;
                     r_pat_valid <= 1'b1;
                     r_tail      <= '0;
                     r_fill      <= '0;
                     r_cnt       <= '0;
                  end
               end
            end
            ST_DETECT: begin
               // A reload overwrites the pattern, so it stops being valid now.
               if (load) begin
                  r_idx       <= '0;
                  r_pat_valid <= 1'b0;
               end else if (din_valid) begin
                  r_tail <= w_hist_n[PAT_W-1:1];
                  if (w_match) begin
                     r_dout <= 1'b1;
                     if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                     r_fill <= ovl_mode ? w_fill_n : '0;
                  end else begin
                     r_fill <= w_fill_n;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign dout      = r_dout;
   assign match_cnt = r_cnt;
   assign busy      = w_busy;
   assign pat_valid = r_pat_valid;

endmodule
